// File: rtl/slm_pkg.sv
// Shared definitions for the SLM command path: UART opcodes, response codes,
// command-sequencer states and SPI frame layout.
package slm_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  // Read/write flag position in the SPI upper byte (1 = read).
  localparam int unsigned SPI_RW_BIT = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_SPI_START,
    S_SPI_WAIT,
    S_TX,
    S_TX_WAIT
  } state_e;

endpackage

// File: rtl/slm_timeout_ctr.sv
// Saturating inactivity counter; expire_o is high while enabled at the limit.
module slm_timeout_ctr #(
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CLKS - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i && (cnt_q == Limit);

endmodule

// File: rtl/slm_spi_cmd_ctrl.sv
// Turns 3-byte UART command frames into single SPI register transactions and
// returns a one-byte ACK/NAK/read-data response.
module slm_spi_cmd_ctrl
  import slm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_spi_start,
  output logic [7:0] o_spi_upper,
  output logic [7:0] o_spi_lower,
  input  logic       i_spi_busy,
  input  logic       i_spi_done,
  input  logic [7:0] i_spi_rx,
  output logic       o_busy,
  output logic       o_frame_err
);

  state_e     state_d, state_q;
  logic [7:0] opcode_d, opcode_q;
  logic [7:0] addr_d, addr_q;
  logic [7:0] spi_upper_d, spi_upper_q;
  logic [7:0] spi_lower_d, spi_lower_q;
  logic [7:0] tx_byte_d, tx_byte_q;
  logic       frame_err_d, frame_err_q;
  logic       byte_accept, spi_start, tx_dv;
  logic       to_clear, to_enable, to_expire;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    spi_upper_d = spi_upper_q;
    spi_lower_d = spi_lower_q;
    tx_byte_d   = tx_byte_q;
    frame_err_d = 1'b0;
    byte_accept = 1'b0;
    spi_start   = 1'b0;
    tx_dv       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_rx_dv) begin
          opcode_d    = i_rx_byte;
          byte_accept = 1'b1;
          state_d     = S_ADDR;
        end
      end
      // An arriving byte takes priority over a coincident timeout.
      S_ADDR: begin
        if (i_rx_dv) begin
          addr_d      = i_rx_byte;
          byte_accept = 1'b1;
          state_d     = S_DATA;
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DATA: begin
        if (i_rx_dv) begin
          byte_accept = 1'b1;
          if (opcode_q == OP_WRITE) begin
            spi_upper_d = {1'b0, addr_q[6:0]};
            spi_lower_d = i_rx_byte;
            state_d     = S_SPI_START;
          end else if (opcode_q == OP_READ) begin
            spi_upper_d             = {1'b0, addr_q[6:0]};
            spi_upper_d[SPI_RW_BIT] = 1'b1;
            spi_lower_d             = 8'h00;
            state_d                 = S_SPI_START;
          end else begin
            tx_byte_d = RESP_NAK;
            state_d   = S_TX;
          end
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_SPI_START: begin
        frame_err_d = i_rx_dv;
        if (!i_spi_busy) begin
          spi_start = 1'b1;
          state_d   = S_SPI_WAIT;
        end
      end
      S_SPI_WAIT: begin
        frame_err_d = i_rx_dv;
        if (i_spi_done) begin
          tx_byte_d = spi_upper_q[SPI_RW_BIT] ? i_spi_rx : RESP_ACK;
          state_d   = S_TX;
        end else if (to_expire) begin
          frame_err_d = 1'b1;
          tx_byte_d   = RESP_NAK;
          state_d     = S_TX;
        end
      end
      S_TX: begin
        frame_err_d = i_rx_dv;
        if (!i_tx_active) begin
          tx_dv   = 1'b1;
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        frame_err_d = i_rx_dv;
        if (i_tx_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      opcode_q    <= 8'h00;
      addr_q      <= 8'h00;
      spi_upper_q <= 8'h00;
      spi_lower_q <= 8'h00;
      tx_byte_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      spi_upper_q <= spi_upper_d;
      spi_lower_q <= spi_lower_d;
      tx_byte_q   <= tx_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign to_clear  = byte_accept || (state_d != state_q);
  assign to_enable = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_SPI_WAIT);

  slm_timeout_ctr #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout_ctr (
    .clk_i    (i_clock),
    .rst_ni   (i_reset_n),
    .clear_i  (to_clear),
    .enable_i (to_enable),
    .expire_o (to_expire)
  );

  assign o_tx_dv     = tx_dv;
  assign o_tx_byte   = tx_byte_q;
  assign o_spi_start = spi_start;
  assign o_spi_upper = spi_upper_q;
  assign o_spi_lower = spi_lower_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_slm_spi_cmd_ctrl.sv
// Directed bench for slm_spi_cmd_ctrl: write/read/bad-opcode frames, timeouts,
// SPI back-pressure, dropped bytes and mid-transaction reset.
module tb_slm_spi_cmd_ctrl;

  localparam int unsigned TO = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       spi_start;
  logic [7:0] spi_upper, spi_lower;
  logic       spi_busy = 1'b0;
  logic       spi_done = 1'b0;
  logic [7:0] spi_rx = 8'h00;
  logic       busy, frame_err;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_txdv = 0, n_ferr = 0, n_b2b = 0;
  logic p_start = 1'b0, p_txdv = 1'b0, p_ferr = 1'b0;
  int s0, f0, t0;

  slm_spi_cmd_ctrl #(
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_rx_dv     (rx_dv),
    .i_rx_byte   (rx_byte),
    .o_tx_dv     (tx_dv),
    .o_tx_byte   (tx_byte),
    .i_tx_active (tx_active),
    .i_tx_done   (tx_done),
    .o_spi_start (spi_start),
    .o_spi_upper (spi_upper),
    .o_spi_lower (spi_lower),
    .i_spi_busy  (spi_busy),
    .i_spi_done  (spi_done),
    .i_spi_rx    (spi_rx),
    .o_busy      (busy),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters and back-to-back pulse detector.
  always @(negedge clk) begin
    if (spi_start) n_start <= n_start + 1;
    if (tx_dv) n_txdv <= n_txdv + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if ((spi_start && p_start) || (tx_dv && p_txdv) || (frame_err && p_ferr)) n_b2b <= n_b2b + 1;
    p_start <= spi_start;
    p_txdv  <= tx_dv;
    p_ferr  <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    step();
    rx_dv   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic do_spi(input logic [7:0] rd);
    spi_rx   = rd;
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    spi_rx   = 8'h00;
  endtask

  task automatic finish_tx();
    tx_active = 1'b1;
    repeat (3) step();
    tx_active = 1'b0;
    tx_done   = 1'b1;
    step();
    tx_done   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {5'd0, tx_dv, spi_start, frame_err, tx_byte, spi_upper, spi_lower}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Write 57 78 A5
    send_byte(8'h57);
    @(negedge clk) check("wr_busy", 32'(busy), 32'd1);
    send_byte(8'h78);
    send_byte(8'hA5);
    @(negedge clk);
    check("wr_start", 32'(spi_start), 32'd1);
    check("wr_upper", 32'(spi_upper), 32'h78);
    check("wr_lower", 32'(spi_lower), 32'hA5);
    step();
    @(negedge clk) check("wr_start_1cyc", 32'(spi_start), 32'd0);
    step();
    do_spi(8'hFF);
    @(negedge clk);
    check("wr_txdv", 32'(tx_dv), 32'd1);
    check("wr_txbyte", 32'(tx_byte), 32'h06);
    step();
    finish_tx();
    check("wr_idle", 32'(busy), 32'd0);
    check("wr_pulses", {16'(n_start), 16'(n_txdv)}, {16'd1, 16'd1});

    // Read 52 78 00 returning 3C
    send_frame(8'h52, 8'h78, 8'h00);
    @(negedge clk);
    check("rd_start", 32'(spi_start), 32'd1);
    check("rd_upper", 32'(spi_upper), 32'hF8);
    check("rd_lower", 32'(spi_lower), 32'h00);
    step();
    do_spi(8'h3C);
    @(negedge clk);
    check("rd_txdv", 32'(tx_dv), 32'd1);
    check("rd_txbyte", 32'(tx_byte), 32'h3C);
    step();
    finish_tx();

    // Bad opcode 41 10 20
    s0 = n_start;
    send_frame(8'h41, 8'h10, 8'h20);
    @(negedge clk);
    check("bad_txdv", 32'(tx_dv), 32'd1);
    check("bad_txbyte", 32'(tx_byte), 32'h15);
    check("bad_upper_held", 32'(spi_upper), 32'hF8);
    step();
    finish_tx();
    check("bad_no_start", 32'(n_start), 32'(s0));
    check("bad_idle", 32'(busy), 32'd0);

    // Inter-byte timeout after opcode
    f0 = n_ferr;
    send_byte(8'h57);
    repeat (TO - 1) step();
    @(negedge clk) check("to_pre", {30'd0, frame_err, busy}, 32'd1);
    step();
    @(negedge clk) check("to_fire", {30'd0, frame_err, busy}, 32'd2);
    step();
    check("to_once", 32'(n_ferr), 32'(f0 + 1));
    send_frame(8'h57, 8'h01, 8'h02);
    @(negedge clk) check("to_next", {7'd0, spi_start, spi_upper, spi_lower, 8'd0}, 32'h01_01_02_00);
    step();
    do_spi(8'h00);
    @(negedge clk) check("to_next_resp", {23'd0, tx_dv, tx_byte}, 32'h106);
    step();
    finish_tx();

    // Byte arriving on the timeout cycle is accepted
    f0 = n_ferr;
    send_byte(8'h57);
    repeat (TO - 1) step();
    send_byte(8'h33);
    @(negedge clk) check("race_busy", {30'd0, frame_err, busy}, 32'd1);
    send_byte(8'h44);
    @(negedge clk) check("race_spi", {15'd0, spi_start, spi_upper, spi_lower}, 32'h1_33_44);
    step();
    do_spi(8'h00);
    step();
    finish_tx();
    check("race_no_ferr", 32'(n_ferr), 32'(f0));

    // SPI master busy, then a byte dropped during S_SPI_WAIT
    spi_busy = 1'b1;
    send_frame(8'h57, 8'h05, 8'h06);
    s0 = n_start;
    repeat (20) step();
    check("bsy_held", 32'(n_start), 32'(s0));
    spi_busy = 1'b0;
    @(negedge clk) check("bsy_start", 32'(spi_start), 32'd1);
    step();
    @(negedge clk) check("bsy_start_1cyc", 32'(spi_start), 32'd0);
    f0 = n_ferr;
    send_byte(8'hAA);
    @(negedge clk) check("drop_ferr", {30'd0, frame_err, busy}, 32'd3);
    step();
    do_spi(8'h99);
    @(negedge clk) check("drop_resp", {23'd0, tx_dv, tx_byte}, 32'h106);
    step();
    finish_tx();
    check("drop_once", 32'(n_ferr), 32'(f0 + 1));

    // SPI completion timeout returns NAK
    send_frame(8'h57, 8'h0A, 8'h0B);
    step();
    repeat (TO - 1) step();
    @(negedge clk) check("spito_pre", {30'd0, frame_err, tx_dv}, 32'd0);
    step();
    @(negedge clk) check("spito_fire", {22'd0, frame_err, tx_dv, tx_byte}, 32'h315);
    step();
    finish_tx();

    // Reset during S_SPI_WAIT
    send_frame(8'h52, 8'h11, 8'h00);
    @(negedge clk) check("rst_mid_start", 32'(spi_start), 32'd1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_outs", {5'd0, tx_dv, spi_start, frame_err, tx_byte, spi_upper, spi_lower}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    t0 = n_txdv;
    do_spi(8'h3C);
    repeat (4) step();
    check("rst_no_tx", 32'(n_txdv), 32'(t0));
    check("rst_idle", 32'(busy), 32'd0);

    check("no_back_to_back", 32'(n_b2b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slm_spi_cmd_ctrl.md
# slm_spi_cmd_ctrl

Command sequencer between the PC UART link and the Bluejay SLM SPI master. Parses 3-byte command frames from the UART receiver and turns each into one 16-bit SPI register transaction. It returns a one-byte response through the UART transmitter: ACK, NAK or the read data. It is the only block that drives the SPI master's start, address and data inputs.

## Interface
- TIMEOUT_CLKS, 50000: maximum gap, in clocks, between frame bytes, and also the limit on SPI completion. This is 1 ms at 50 MHz.
- OP_WRITE, 8'h57: ASCII 'W' opcode.
- OP_READ, 8'h52: ASCII 'R' opcode.
- RESP_ACK, 8'h06: response to a completed write.
- RESP_NAK, 8'h15: response to a bad opcode or an SPI timeout.
- i_clock  in  1  system clock; one clock domain only.
- i_reset_n  in  1  reset, asynchronous and active-low.
- i_rx_dv  in  1  one-cycle strobe; a UART byte is valid.
- i_rx_byte  in  8  received byte.
- o_tx_dv  out  1  one-cycle strobe to start a UART transmit.
- o_tx_byte  out  8  response byte; held from o_tx_dv until i_tx_done.
- i_tx_active  in  1  UART transmitter busy.
- i_tx_done  in  1  one-cycle strobe; transmit finished.
- o_spi_start  out  1  one-cycle strobe to start the SPI transfer.
- o_spi_upper  out  8  SPI upper byte: {rw, addr[6:0]}.
- o_spi_lower  out  8  SPI lower byte: write data, or 8'h00 for a read.
- i_spi_busy  in  1  SPI master busy.
- i_spi_done  in  1  one-cycle strobe; SPI transaction complete.
- i_spi_rx  in  8  SPI read byte; valid on the i_spi_done cycle.
- o_busy  out  1  high in every state except S_IDLE.
- o_frame_err  out  1  one-cycle strobe on a timeout or a dropped byte.

## Operation
- Frame format: opcode, address, data. All three bytes are required for both reads and writes; the data byte is ignored on a read.
- S_IDLE: the next i_rx_dv latches the opcode and moves to S_ADDR.
- S_ADDR: the next i_rx_dv latches the address and moves to S_DATA.
- S_DATA: the next i_rx_dv latches the data byte. Then:
  - opcode OP_WRITE or OP_READ: go to S_SPI_START.
  - any other opcode: o_tx_byte=RESP_NAK and go to S_TX. No SPI activity.
- S_SPI_START: wait while i_spi_busy=1. Then pulse o_spi_start for one cycle and go to S_SPI_WAIT. The upper and lower bytes are set as follows:
  - write: o_spi_upper={1'b0, addr[6:0]}, o_spi_lower=data.
  - read: o_spi_upper={1'b1, addr[6:0]}, o_spi_lower=8'h00.
- S_SPI_WAIT: on i_spi_done, set o_tx_byte to i_spi_rx for a read or RESP_ACK for a write, then go to S_TX.
- S_TX: wait while i_tx_active=1. Then pulse o_tx_dv for one cycle and go to S_TX_WAIT.
- S_TX_WAIT: on i_tx_done, go to S_IDLE.
- Timeout counter: cleared on every state change and on every accepted byte; counts in S_ADDR, S_DATA and S_SPI_WAIT.
  - Count reaches TIMEOUT_CLKS-1 in S_ADDR or S_DATA: pulse o_frame_err, discard the partial frame, go to S_IDLE.
  - Count reaches TIMEOUT_CLKS-1 in S_SPI_WAIT: pulse o_frame_err, o_tx_byte=RESP_NAK, go to S_TX.
- An i_rx_dv in S_SPI_START, S_SPI_WAIT, S_TX or S_TX_WAIT drops the byte and pulses o_frame_err. The state is unaffected.
- If a timeout and i_rx_dv land on the same cycle in S_ADDR or S_DATA, the byte wins: it is accepted and the counter clears.
- Counter width is $clog2(TIMEOUT_CLKS). It saturates and never wraps.

## Timing
- Reset values: state S_IDLE. All outputs are 0: o_tx_dv, o_tx_byte, o_spi_start, o_spi_upper, o_spi_lower, o_busy, o_frame_err.
- Assertion of i_reset_n=0 in any state, including mid-SPI or mid-TX, returns immediately to S_IDLE with all outputs 0. No response byte is sent.
- Third byte accepted at cycle N. With i_spi_busy=0, o_spi_start is high at N+1 only.
- o_spi_upper and o_spi_lower are valid from N+1 and held until the next frame's S_SPI_START.
- i_spi_done at cycle M. With i_tx_active=0, o_tx_dv is high at M+1.
- o_frame_err, o_spi_start and o_tx_dv are never high for two consecutive cycles.
- o_busy rises the cycle after the opcode byte and falls the cycle after i_tx_done.

## Structure
- Shared package slm_pkg:
  - opcode constants.
  - RESP_ACK and RESP_NAK.
  - state enum: S_IDLE, S_ADDR, S_DATA, S_SPI_START, S_SPI_WAIT, S_TX, S_TX_WAIT.
  - SPI rw-bit position (bit 7).
- One sub-module, slm_timeout_ctr: clear and enable inputs, an expire output, parameterised by TIMEOUT_CLKS.
- The FSM and datapath registers stay in slm_spi_cmd_ctrl.

## Test plan
- Write frame 57 78 A5: o_spi_upper=78, o_spi_lower=A5, one o_spi_start pulse. After i_spi_done, o_tx_byte=06 with one o_tx_dv pulse.
- Read frame 52 78 00 with i_spi_rx=3C on i_spi_done: o_spi_upper=F8, o_spi_lower=00, then o_tx_byte=3C.
- Bad opcode 41 10 20: no o_spi_start; o_tx_byte=15.
- Send 57 then wait TIMEOUT_CLKS clocks: o_frame_err pulses once and o_busy=0. The next frame 57 01 02 then works normally.
- i_spi_busy=1 held for 20 cycles at S_SPI_START: o_spi_start waits and pulses one cycle after busy falls. A byte injected during S_SPI_WAIT pulses o_frame_err and the response is unchanged.
- Reset asserted in S_SPI_WAIT: all outputs are 0 the same cycle. A later i_spi_done produces no o_tx_dv.
